// File: rtl/spi_reg_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Package     : spi_pkg
// Description : Shared constants for the SPI front end and register bridge:
//               frame status bit positions, bridge FSM state encoding and
//               default bus widths / error data.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

   // Bus / SPI widths shared with spi_data_path
   localparam int ADDR_W_DEF = 20;
   localparam int DATA_W_DEF = 16;

   // Value returned to the SPI master when a read is aborted
   localparam logic [15:0] ERR_DATA_DEF = 16'hDEAD;

   // Frame status bit positions
   localparam int ST_WRITE = 2;
   localparam int ST_BURST = 1;

   // Bridge FSM state encoding
   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_RD_REQ       = 3'd1;
   localparam logic [2:0] S_WR_WAIT_DATA = 3'd2;
   localparam logic [2:0] S_WR_REQ       = 3'd3;
   localparam logic [2:0] S_ERR_HOLD     = 3'd4;

endpackage
`default_nettype wire

// File: rtl/spi_reg_bridge_if.sv
`default_nettype none
// ============================================================================
// Interface   : spi_reg_bridge_if
// Description : Internal single-beat register bus between the SPI bridge
//               (master) and the crypto core register file (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_reg_bridge_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
) ();
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_rdata, bus_ack
   );
endinterface
`default_nettype wire

// File: rtl/spi_reg_bridge_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : spi_edge_det
// Description : Registered rising-edge detector. The level input is already
//               in the clk domain; the rise pulse is registered so the FSM
//               sees a clean one-cycle strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_det (
   input  wire  clk,
   input  wire  reset_n,
   input  wire  i_level,
   output logic o_rise
);
   logic r_q;
   logic r_rise;

   // Track previous level and register the rising-edge strobe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q    <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_q    <= i_level;
         r_rise <= i_level & ~r_q;
      end
   end

   assign o_rise = r_rise;
endmodule
`default_nettype wire

// File: rtl/spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_bridge
// Description : Turns decoded SPI frames into single-beat register bus
//               transactions. Reads are prefetched on the address edge so
//               rdata is ready for MISO shift-out; writes wait for the data
//               frame. Burst frames auto-increment on every further data edge.
//               Unanswered requests are aborted after TIMEOUT cycles and flag
//               a sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_bridge
   import spi_pkg::*;
#(
   parameter int               ADDR_W   = ADDR_W_DEF,
   parameter int               DATA_W   = DATA_W_DEF,
   parameter int               TIMEOUT  = 255,
   parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
   input  wire                clk,
   input  wire                reset_n,
   input  wire                address_ready,
   input  wire                data_ready,
   input  wire  [ADDR_W-1:0]  addr,
   input  wire  [3:0]         status,
   input  wire  [DATA_W-1:0]  wdata,
   output logic [DATA_W-1:0]  rdata,
   output logic               busy,
   output logic               err,
   input  wire                err_clr,
   spi_reg_bridge_if.master   bus
);
   // Counter value on the last cycle a request may stay outstanding
   localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

   logic              w_ar_rise;
   logic              w_dr_rise;
   logic [2:0]        r_state;
   logic [2:0]        w_next;
   logic [ADDR_W-1:0] r_cur_addr;
   logic              r_we;
   logic              r_burst;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic [7:0]        r_cnt;
   logic              r_err;
   logic              w_in_req;
   logic              w_expire;
   logic              w_frame_start;
   logic              w_beat;
   logic              w_bus_req;
   logic              w_bus_we;
   logic              w_busy;
   logic              w_unused_status;

   // Reserved status bits carry no meaning for the bridge
   assign w_unused_status = status[3] ^ status[0];

   spi_edge_det u_ar_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .i_level (address_ready),
      .o_rise  (w_ar_rise)
   );

   spi_edge_det u_dr_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .i_level (data_ready),
      .o_rise  (w_dr_rise)
   );

   assign w_in_req      = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
   // An ack on the final allowed cycle still counts as success
   assign w_expire      = w_in_req && !bus.bus_ack && (r_cnt == c_TMO_LAST);
   // A new address frame is accepted while idle or while a write waits for data
   assign w_frame_start = w_ar_rise && ((r_state == S_IDLE) || (r_state == S_WR_WAIT_DATA));
   // Follow-on burst beat; an address edge in the same cycle takes priority
   assign w_beat        = w_dr_rise && !w_ar_rise && (r_state == S_IDLE) && r_burst;

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // FSM next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_ar_rise)   w_next = status[ST_WRITE] ? S_WR_WAIT_DATA : S_RD_REQ;
            else if (w_beat) w_next = r_we ? S_WR_REQ : S_RD_REQ;
         end
         S_WR_WAIT_DATA: begin
            if (w_ar_rise)      w_next = status[ST_WRITE] ? S_WR_WAIT_DATA : S_RD_REQ;
            else if (w_dr_rise) w_next = S_WR_REQ;
         end
         S_RD_REQ, S_WR_REQ: begin
            if (bus.bus_ack)   w_next = S_IDLE;
            else if (w_expire) w_next = S_ERR_HOLD;
         end
         S_ERR_HOLD: w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // FSM outputs decoded from the current state
   always_comb begin
      w_bus_req = w_in_req;
      w_bus_we  = (r_state == S_WR_REQ);
      w_busy    = (r_state != S_IDLE);
   end

   // Frame context, write data, timeout counter, read data and error flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cur_addr <= '0;
         r_we       <= 1'b0;
         r_burst    <= 1'b0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_cnt      <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_frame_start) begin
            r_cur_addr <= addr;
            r_we       <= status[ST_WRITE];
            r_burst    <= status[ST_BURST];
         end else if (w_beat) begin
            r_cur_addr <= r_cur_addr + ADDR_W'(1);
            if (r_we) r_wdata <= wdata;
         end else if ((r_state == S_WR_WAIT_DATA) && w_dr_rise) begin
            r_wdata <= wdata;
         end

         if (!w_in_req)         r_cnt <= '0;
         else if (!bus.bus_ack) r_cnt <= r_cnt + 8'd1;

         if ((r_state == S_RD_REQ) && bus.bus_ack) r_rdata <= bus.bus_rdata;
         else if ((r_state == S_RD_REQ) && w_expire) r_rdata <= ERR_DATA;

         if (w_expire)     r_err <= 1'b1;
         else if (err_clr) r_err <= 1'b0;
      end
   end

   assign bus.bus_req   = w_bus_req;
   assign bus.bus_we    = w_bus_we;
   assign bus.bus_addr  = r_cur_addr;
   assign bus.bus_wdata = r_wdata;
   assign rdata         = r_rdata;
   assign busy          = w_busy;
   assign err           = r_err;
endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_bridge
// Description : Scoreboard bench for spi_reg_bridge. Frame stimulus feeds a
//               transaction-level reference model that queues expected bus
//               transactions; a monitor checks each bus request and each
//               completion (read data, timeout aborts) against the queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_bridge;
   import spi_pkg::*;

   localparam int AW  = 20;
   localparam int DW  = 16;
   localparam int TMO = 255;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          address_ready = 1'b0;
   logic          data_ready = 1'b0;
   logic          err_clr = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [3:0]    status = '0;
   logic [DW-1:0] wdata = '0;
   wire  [DW-1:0] rdata;
   wire           busy;
   wire           err;

   spi_reg_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

   spi_reg_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .ERR_DATA(16'hDEAD)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .address_ready (address_ready),
      .data_ready    (data_ready),
      .addr          (addr),
      .status        (status),
      .wdata         (wdata),
      .rdata         (rdata),
      .busy          (busy),
      .err           (err),
      .err_clr       (err_clr),
      .bus           (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } txn_t;

   txn_t          exp_q[$];
   logic [DW-1:0] rd_q[$];
   logic [DW-1:0] fixed_q[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   bit            mute = 1'b0;
   int            fix_dly = -1;
   logic [DW-1:0] last_rd = '0;

   // Transaction-level model of the current frame
   logic [AW-1:0] m_addr = '0;
   bit            m_we = 1'b0;
   bit            m_burst = 1'b0;
   bit            m_wait = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic void model_start(input logic [AW-1:0] a, input logic [3:0] st);
      txn_t t;
      m_addr  = a;
      m_we    = st[2];
      m_burst = st[1];
      m_wait  = st[2];
      if (!m_we) begin
         t.we = 1'b0; t.a = a; t.d = '0;
         exp_q.push_back(t);
      end
   endfunction

   function automatic void model_beat(input logic [DW-1:0] d);
      txn_t    t;
      longint  nxt;
      if (m_wait) begin
         t.we = 1'b1; t.a = m_addr; t.d = d;
         exp_q.push_back(t);
         m_wait = 1'b0;
      end else if (m_burst) begin
         nxt    = (longint'(m_addr) + 1) % (longint'(1) << AW);
         m_addr = nxt[AW-1:0];
         t.we = m_we; t.a = m_addr; t.d = m_we ? d : '0;
         exp_q.push_back(t);
      end
   endfunction

   // Register-bus slave: acks each request after a short delay unless muted
   initial begin
      int dly;
      dly = 2;
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (!reset_n) begin
            bus_if.bus_ack = 1'b0;
         end else if (bus_if.bus_ack) begin
            bus_if.bus_ack = 1'b0;
         end else if (bus_if.bus_req && !mute) begin
            if (dly <= 0) begin
               bus_if.bus_ack = 1'b1;
               if (!bus_if.bus_we) begin
                  bus_if.bus_rdata = (fixed_q.size() > 0) ? fixed_q.pop_front() : DW'($urandom);
                  rd_q.push_back(bus_if.bus_rdata);
               end else begin
                  bus_if.bus_rdata = DW'($urandom);
               end
               dly = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 4));
            end else begin
               dly--;
            end
         end
      end
   end

   // Monitor: checks request contents and completion results
   initial begin
      bit            prev_req, prev_ack, prev_we;
      int            len;
      txn_t          t;
      logic [DW-1:0] e;
      prev_req = 0; prev_ack = 0; prev_we = 0; len = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_req = 0; prev_ack = 0; prev_we = 0; len = 0;
            continue;
         end
         if (bus_if.bus_req && !prev_req) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL bus_req: got request to %0h we=%0b, required none", bus_if.bus_addr, bus_if.bus_we);
            end else begin
               t = exp_q.pop_front();
               check("bus_we", bus_if.bus_we, t.we);
               check("bus_addr", bus_if.bus_addr, t.a);
               if (t.we) check("bus_wdata", bus_if.bus_wdata, t.d);
            end
         end
         if (bus_if.bus_req) len++;
         if (prev_req && !bus_if.bus_req) begin
            if (prev_ack) begin
               if (!prev_we) begin
                  if (rd_q.size() == 0) begin
                     n_cmp++; n_bad++;
                     $display("FAIL rdata: got completion with no issued read data, rdata=%0h", rdata);
                  end else begin
                     e = rd_q.pop_front();
                     check("rdata", rdata, e);
                     last_rd = e;
                  end
               end
            end else begin
               check("abort_expected", mute, 1);
               check("timeout_len", len, TMO);
               check("err_after_timeout", err, 1);
               if (!prev_we) begin
                  check("rdata_err_data", rdata, 16'hDEAD);
                  last_rd = 16'hDEAD;
               end
            end
            len = 0;
         end
         prev_req = bus_if.bus_req;
         prev_ack = bus_if.bus_ack;
         prev_we  = bus_if.bus_we;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 400) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
      end
   endtask

   task automatic do_frame(input logic [AW-1:0] a, input logic [3:0] st, input int beats,
                           input logic [DW-1:0] wd0);
      logic [DW-1:0] d;
      @(posedge clk); #1;
      addr = a; status = st; address_ready = 1'b1;
      model_start(a, st);
      @(posedge clk); #1;
      check("req_latency_1", bus_if.bus_req, 0);
      @(posedge clk); #1;
      if (st[2]) begin
         check("wr_wait_req", bus_if.bus_req, 0);
         check("wr_wait_busy", busy, 1);
      end else begin
         check("rd_req_latency_2", bus_if.bus_req, 1);
         wait_idle();
      end
      for (int i = 0; i < beats; i++) begin
         d = (i == 0) ? wd0 : DW'($urandom);
         wdata = d; data_ready = 1'b1;
         model_beat(d);
         repeat (2) @(posedge clk);
         #1;
         wait_idle();
         data_ready = 1'b0;
         @(posedge clk); #1;
      end
      address_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   // Watchdog
   initial begin
      #2_000_000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Directed and random stimulus
   initial begin
      logic [3:0] st;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rdata", rdata, 0);
      check("rst_bus_req", bus_if.bus_req, 0);
      check("rst_bus_we", bus_if.bus_we, 0);
      check("rst_bus_addr", bus_if.bus_addr, 0);
      check("rst_bus_wdata", bus_if.bus_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Single read with a fixed 3-cycle ack delay
      fix_dly = 3;
      fixed_q.push_back(16'hBEEF);
      do_frame(20'h00123, 4'b0000, 0, '0);
      check("single_read_rdata", rdata, 16'hBEEF);
      check("single_read_err", err, 0);

      // Single write; rdata must not move
      do_frame(20'h00123, 4'b0100, 1, 16'hA5A5);
      check("write_keeps_rdata", rdata, 16'hBEEF);

      // Burst read across the address wrap
      fixed_q.push_back(16'd1); fixed_q.push_back(16'd2);
      fixed_q.push_back(16'd3); fixed_q.push_back(16'd4);
      do_frame(20'hFFFFF, 4'b0010, 3, '0);
      check("burst_last_rdata", rdata, 16'd4);
      fix_dly = -1;

      // Read timeout, then write timeout
      mute = 1'b1;
      do_frame(20'h0ABCD, 4'b0000, 0, '0);
      check("timeout_err", err, 1);
      do_frame(20'h00042, 4'b0100, 1, 16'h1234);
      mute = 1'b0;
      check("wr_timeout_keeps_rdata", rdata, 16'hDEAD);

      // Normal read with sticky err, then clear
      do_frame(20'h00055, 4'b0000, 0, '0);
      check("err_sticky", err, 1);
      @(posedge clk); #1; err_clr = 1'b1;
      @(posedge clk); #1; err_clr = 1'b0;
      check("err_cleared", err, 0);

      // Reset in the middle of an outstanding read
      mute = 1'b1;
      @(posedge clk); #1;
      addr = 20'h00777; status = 4'b0000; address_ready = 1'b1;
      model_start(20'h00777, 4'b0000);
      repeat (3) @(posedge clk);
      #1;
      check("req_before_reset", bus_if.bus_req, 1);
      reset_n = 1'b0;
      #1;
      check("reset_bus_req", bus_if.bus_req, 0);
      check("reset_busy", busy, 0);
      check("reset_rdata", rdata, 0);
      check("reset_bus_addr", bus_if.bus_addr, 0);
      last_rd = '0;
      @(posedge clk); #1;
      address_ready = 1'b0; mute = 1'b0;
      exp_q.delete(); rd_q.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
      do_frame(20'h00321, 4'b0000, 0, '0);
      check("read_after_reset_err", err, 0);

      // Address edge and data edge together in a burst-write context
      do_frame(20'h01000, 4'b0110, 1, 16'h5A5A);
      @(posedge clk); #1;
      addr = 20'h02000; status = 4'b0000; wdata = 16'hFFFF;
      address_ready = 1'b1; data_ready = 1'b1;
      model_start(20'h02000, 4'b0000);
      repeat (3) @(posedge clk);
      #1;
      wait_idle();
      address_ready = 1'b0; data_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Randomised frames
      for (int i = 0; i < 40; i++) begin
         st = 4'($urandom);
         if (st[2]) do_frame(AW'($urandom), st, int'($urandom_range(1, 3)), DW'($urandom));
         else       do_frame(AW'($urandom), st, int'($urandom_range(0, 3)), DW'($urandom));
      end

      repeat (4) @(posedge clk);
      #1;
      check("exp_queue_empty", exp_q.size(), 0);
      check("rd_queue_empty", rd_q.size(), 0);
      check("final_err", err, 0);
      check("final_rdata", rdata, last_rd);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
